quad_encoder_multi: RTL
=======================

Name: quad_encoder_multi

Overview:
- Multi-channel, fully synchronous quadrature encoder interface.
- Next generation of the edge-clocked single-channel decoder: one system clock, parametrised channel count and widths.
- Per channel: input synchroniser, glitch filter, x4 decoding, illegal-transition detection and period measurement with timeout.
- Sits between the encoder input pins and the motor-control register block; software and the velocity loop read pos/per directly.

Parameters:
NUM_CH, 4, number of encoder channels
POS_W, 32, position counter width (two's complement, wraps)
PER_W, 32, period output width (clock cycles)
FILT_LEN, 3, consecutive equal samples required to accept a new input level (1..15)
MAX_PERIOD, 20000000, period timeout in clocks; also the value reported on reversal

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enc_a  in  NUM_CH  phase A per channel, asynchronous
enc_b  in  NUM_CH  phase B per channel, asynchronous
enc_z  in  NUM_CH  index per channel, asynchronous
clr  in  NUM_CH  synchronous clear of pos, err, per state for that channel
pos  out  NUM_CH*POS_W  signed position, channel i at [i*POS_W +: POS_W]
per  out  NUM_CH*PER_W  clocks between last two same-direction counts
dir  out  NUM_CH  direction of last count: 0 = up, 1 = down
err  out  NUM_CH  sticky illegal-transition flag
idx_valid  out  NUM_CH  one-cycle pulse on index capture
idx_pos  out  NUM_CH*POS_W  position captured at index

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values: all outputs 0 except per = SAT, where SAT = min(MAX_PERIOD, 2^(PER_W-1)-1). Filter state = 0, init flag = 0.
- Synchroniser: 2 flops per input.
- Filter: a new filtered level is accepted when the synchronised level has differed from the filtered level for FILT_LEN consecutive clocks. Any interruption restarts the run counter.
- Init: the first filtered AB after reset or clr only loads the decoder state (init flag set). No count, no err.
- Decoding (filtered AB, previous -> current):
  - Up (+1, dir=0): 00->01->11->10->00.
  - Down (-1, dir=1): the reverse sequence.
  - No change: nothing happens.
  - Both bits changed: pos and dir hold, err <= 1 (sticky until clr or reset).
- Latency: pos/dir/per update 1 clk after the filtered level changes. Pin-to-pos is 2 + FILT_LEN + 1 clocks.
- pos wraps modulo 2^POS_W with no saturation.
- Period counter (per channel): increments every clk and saturates at MAX_PERIOD. On a count event:
  - Same direction as the previous count: per <= counter value.
  - Reversal, or first count after init: per <= SAT.
  - In all cases the counter then resets to 1.
- Timeout: counter == MAX_PERIOD forces per <= SAT. per stays SAT until two consecutive same-direction counts occur.
- clr[i] asserted: pos, err, period counter and init flag cleared, per <= SAT, on the next clk.
  - clr has priority over a simultaneous count event.
  - Filter and synchroniser are not cleared.
- Channels are fully independent.
- Reset mid-operation clears everything asynchronously. Re-initialisation follows the init rule, so no spurious err.

Optional Feature:
- Macro: ENC_INDEX_LATCH_EN.
- Defined: enc_z passes through the same sync + filter path. On a filtered Z rising edge, idx_pos <= pos value after that cycle's count update, and idx_valid pulses for 1 clk. Z rising together with clr captures 0.
- Undefined: Z logic is not built; idx_valid and idx_pos are tied 0. Ports remain present.

Decomposition:
- Package quad_enc_pkg contains:
  - state encoding for AB,
  - a function returning {valid, up, down, illegal} from (prev, cur),
  - localparam SAT computation helper.
- Sub-module quad_enc_chan holds one channel: sync, filter, decode, period, index. The top instantiates NUM_CH copies with a generate loop and packs the buses.

Test Plan (NUM_CH=2, FILT_LEN=3, MAX_PERIOD=100, PER_W=16):
- Drive ch0 up-sequence 00,01,11,10,00 with 20-clk steps: pos0 = 4, dir0 = 0, per0 = 20 after the 2nd count, ch1 pos1 = 0.
- 2-clk glitch on A of ch0: pos0 unchanged. A held 3 clks: pos0 +1 exactly 6 clks after the pin change.
- Jump AB 00->11: err0 = 1, pos0 unchanged. err0 stays 1 until clr0 pulse, then err0 = 0 and pos0 = 0.
- Up steps, then one down step: dir0 = 1, per0 = 100 (SAT). Hold the inputs 100+ clks: per0 = 100.
- pos0 preset to 0 via clr, one down step: pos0 = 0xFFFFFFFF (wrap). clr and count in the same clk: pos0 = 0.
- With ENC_INDEX_LATCH_EN: Z rising at pos0 = 37: idx_pos0 = 37, idx_valid0 high for exactly 1 clk. Without the macro: both stay 0.

Source files
------------

// File: rtl/quad_enc_pkg.sv
// rtl/quad_enc_pkg.sv - shared AB state encoding, transition decoder and period saturation helper
package quad_enc_pkg;

  // AB state is packed as {B, A}; the up direction is A leading B.
  typedef enum logic [1:0] {
    AB_00 = 2'b00,
    AB_01 = 2'b01,
    AB_11 = 2'b11,
    AB_10 = 2'b10
  } ab_e;

  typedef struct packed {
    logic valid;
    logic up;
    logic down;
    logic illegal;
  } ab_dec_t;

  localparam int FILT_CNT_W = 4;

  function automatic logic [1:0] ab_next(input logic [1:0] s);
    case (s)
      AB_00:   return AB_01;
      AB_01:   return AB_11;
      AB_11:   return AB_10;
      default: return AB_00;
    endcase
  endfunction

  function automatic ab_dec_t ab_decode(input logic [1:0] prev, input logic [1:0] cur);
    ab_dec_t r;
    r.up      = (ab_next(prev) == cur);
    r.down    = (ab_next(cur) == prev);
    r.illegal = ((prev ^ cur) == 2'b11);
    r.valid   = r.up | r.down;
    return r;
  endfunction

  function automatic longint sat_value(input longint max_period, input int per_w);
    longint lim;
    lim = (longint'(1) << (per_w - 1)) - 1;
    return (max_period < lim) ? max_period : lim;
  endfunction

endpackage

// File: rtl/quad_enc_chan.sv
// rtl/quad_enc_chan.sv - one encoder channel: sync, glitch filter, x4 decode, period, index
// Index capture (Z path) is built only when ENC_INDEX_LATCH_EN is defined.
module quad_enc_chan
  import quad_enc_pkg::*;
#(
  parameter int POS_W      = 32,
  parameter int PER_W      = 32,
  parameter int FILT_LEN   = 3,
  parameter int MAX_PERIOD = 20000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_i,
  input  logic             b_i,
  input  logic             z_i,
  input  logic             clr_i,
  output logic [POS_W-1:0] pos_o,
  output logic [PER_W-1:0] per_o,
  output logic             dir_o,
  output logic             err_o,
  output logic             idx_valid_o,
  output logic [POS_W-1:0] idx_pos_o
);

  localparam longint SAT_L = sat_value(longint'(MAX_PERIOD), PER_W);
  localparam logic [PER_W-1:0] SAT = PER_W'(SAT_L);
  localparam int CNT_W = $clog2(MAX_PERIOD + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PERIOD);
  localparam logic [FILT_CNT_W-1:0] RUN_LAST = FILT_CNT_W'(FILT_LEN - 1);

`ifdef ENC_INDEX_LATCH_EN
  localparam int NIN = 3;
  logic [NIN-1:0] raw;
  assign raw = {z_i, b_i, a_i};
`else
  localparam int NIN = 2;
  logic [NIN-1:0] raw;
  logic           unused_z;
  assign raw      = {b_i, a_i};
  assign unused_z = z_i;
`endif

  logic [NIN-1:0]                 sync1_q, sync2_q, filt_q, filt_d;
  logic [NIN-1:0][FILT_CNT_W-1:0] run_q, run_d;

  // Each input bit needs FILT_LEN consecutive differing samples before it is accepted.
  always_comb begin
    filt_d = filt_q;
    run_d  = '0;
    for (int k = 0; k < NIN; k++) begin
      if (sync2_q[k] != filt_q[k]) begin
        if (run_q[k] == RUN_LAST) filt_d[k] = sync2_q[k];
        else                      run_d[k]  = run_q[k] + FILT_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      filt_q  <= '0;
      run_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      run_q   <= run_d;
    end
  end

  logic [1:0]       ab_cur, prev_q, prev_d;
  logic             init_q, init_d, dir_q, dir_d, err_q, err_d, dvld_q, dvld_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [PER_W-1:0] per_q, per_d, meas;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ab_dec_t          dec;

  assign ab_cur = filt_q[1:0];
  assign dec    = ab_decode(prev_q, ab_cur);
  assign meas   = (longint'(cnt_q) > SAT_L) ? SAT : PER_W'(cnt_q);

  // dvld_q marks that a previous count exists whose interval can be measured.
  always_comb begin
    prev_d = ab_cur;
    init_d = init_q;
    pos_d  = pos_q;
    dir_d  = dir_q;
    err_d  = err_q;
    per_d  = per_q;
    dvld_d = dvld_q;
    cnt_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    if (cnt_q == CNT_MAX) begin
      per_d  = SAT;
      dvld_d = 1'b0;
    end
    if (!init_q) begin
      init_d = 1'b1;
    end else begin
      if (dec.illegal) err_d = 1'b1;
      if (dec.valid) begin
        pos_d  = dec.up ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
        dir_d  = dec.down;
        per_d  = (dvld_q && (dir_q == dec.down) && (cnt_q != CNT_MAX)) ? meas : SAT;
        dvld_d = 1'b1;
        cnt_d  = CNT_W'(1);
      end
    end
    if (clr_i) begin
      pos_d  = '0;
      err_d  = 1'b0;
      cnt_d  = '0;
      init_d = 1'b0;
      per_d  = SAT;
      dvld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
      init_q <= 1'b0;
      pos_q  <= '0;
      dir_q  <= 1'b0;
      err_q  <= 1'b0;
      per_q  <= SAT;
      dvld_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      prev_q <= prev_d;
      init_q <= init_d;
      pos_q  <= pos_d;
      dir_q  <= dir_d;
      err_q  <= err_d;
      per_q  <= per_d;
      dvld_q <= dvld_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pos_o = pos_q;
  assign per_o = per_q;
  assign dir_o = dir_q;
  assign err_o = err_q;

`ifdef ENC_INDEX_LATCH_EN
  logic             zprev_q, idx_valid_q, idx_valid_d;
  logic [POS_W-1:0] idx_pos_q, idx_pos_d;

  always_comb begin
    idx_valid_d = filt_q[2] & ~zprev_q;
    idx_pos_d   = idx_valid_d ? pos_d : idx_pos_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zprev_q     <= 1'b0;
      idx_valid_q <= 1'b0;
      idx_pos_q   <= '0;
    end else begin
      zprev_q     <= filt_q[2];
      idx_valid_q <= idx_valid_d;
      idx_pos_q   <= idx_pos_d;
    end
  end

  assign idx_valid_o = idx_valid_q;
  assign idx_pos_o   = idx_pos_q;
`else
  assign idx_valid_o = 1'b0;
  assign idx_pos_o   = '0;
`endif

endmodule

// File: rtl/quad_encoder_multi.sv
// rtl/quad_encoder_multi.sv - multi-channel quadrature encoder interface, one quad_enc_chan per channel
// Optional index latch per channel is enabled by ENC_INDEX_LATCH_EN.
module quad_encoder_multi #(
  parameter int NUM_CH     = 4,
  parameter int POS_W      = 32,
  parameter int PER_W      = 32,
  parameter int FILT_LEN   = 3,
  parameter int MAX_PERIOD = 20000000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       enc_a,
  input  logic [NUM_CH-1:0]       enc_b,
  input  logic [NUM_CH-1:0]       enc_z,
  input  logic [NUM_CH-1:0]       clr,
  output logic [NUM_CH*POS_W-1:0] pos,
  output logic [NUM_CH*PER_W-1:0] per,
  output logic [NUM_CH-1:0]       dir,
  output logic [NUM_CH-1:0]       err,
  output logic [NUM_CH-1:0]       idx_valid,
  output logic [NUM_CH*POS_W-1:0] idx_pos
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    quad_enc_chan #(
      .POS_W      (POS_W),
      .PER_W      (PER_W),
      .FILT_LEN   (FILT_LEN),
      .MAX_PERIOD (MAX_PERIOD)
    ) u_chan (
      .clk         (clk),
      .rst_n       (rst_n),
      .a_i         (enc_a[i]),
      .b_i         (enc_b[i]),
      .z_i         (enc_z[i]),
      .clr_i       (clr[i]),
      .pos_o       (pos[i*POS_W +: POS_W]),
      .per_o       (per[i*PER_W +: PER_W]),
      .dir_o       (dir[i]),
      .err_o       (err[i]),
      .idx_valid_o (idx_valid[i]),
      .idx_pos_o   (idx_pos[i*POS_W +: POS_W])
    );
  end

endmodule
